// File: rtl/video_shift_tap_ctrl.sv
// Line-RAM address/enable controller for the video shift tap.
// Optional SHIFT_TAP_LINE_CNT_EN adds a completed-line counter output.
module video_shift_tap_ctrl #(
    parameter int DSIZE = 24,
    parameter int ASIZE = 10
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_vs,
    input  logic             in_de,
    input  logic [DSIZE-1:0] in_data,
    output logic             ram_wr_en,
    output logic [ASIZE-1:0] ram_wr_addr,
    output logic [DSIZE-1:0] ram_wr_data,
    output logic             ram_rd_en,
    output logic [ASIZE-1:0] ram_rd_addr,
    input  logic [DSIZE-1:0] ram_rd_data,
    output logic             out_de,
    output logic [DSIZE-1:0] out_cur,
    output logic [DSIZE-1:0] out_prev,
    output logic             out_prev_vld,
    output logic [ASIZE:0]   line_len,
`ifdef SHIFT_TAP_LINE_CNT_EN
    output logic [11:0]      line_cnt,
`endif
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        RUN
    } state_t;

    state_t         state;
    logic [ASIZE:0] col;
    logic [ASIZE:0] col_eff;
    logic [ASIZE:0] col_nxt;
    logic           sat;
    logic           fall;
    logic           vld;

    // A pixel coincident with in_vs is column 0 of the new frame
    assign col_eff = in_vs ? '0 : col;
    assign sat     = col_eff[ASIZE];
    assign col_nxt = sat ? col_eff : col_eff + 1'b1;
    assign fall    = out_de & ~in_de;

    assign ram_rd_en   = rst_n & in_de & ~sat;
    assign ram_rd_addr = col_eff[ASIZE-1:0];
    assign out_prev    = ram_rd_data;

    assign vld = in_de & ~in_vs & (state == RUN) & ~sat
               & (col_eff < line_len);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            out_de       <= 1'b0;
            out_cur      <= '0;
            out_prev_vld <= 1'b0;
            ram_wr_en    <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
            line_len     <= '0;
            overflow     <= 1'b0;
        end else begin
            out_de       <= in_de;
            out_cur      <= in_data;
            out_prev_vld <= vld;
            // Write lags the read by one cycle so old data is read first
            ram_wr_en    <= in_de & ~sat;
            ram_wr_addr  <= col_eff[ASIZE-1:0];
            ram_wr_data  <= in_data;
            col          <= in_de ? col_nxt : '0;
            if (fall)
                line_len <= col;
            if (in_vs)
                overflow <= 1'b0;
            else if (in_de && sat)
                overflow <= 1'b1;
            if (in_vs) begin
                state <= in_de ? FIRST : IDLE;
            end else begin
                unique case (state)
                    IDLE:    if (in_de) state <= FIRST;
                    FIRST:   if (fall) state <= RUN;
                    RUN:     state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SHIFT_TAP_LINE_CNT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            line_cnt <= '0;
        else if (in_vs)
            line_cnt <= '0;
        else if (fall && line_cnt != 12'hfff)
            line_cnt <= line_cnt + 12'd1;
    end
`endif

endmodule

// File: tb/tb_video_shift_tap_ctrl.sv
// Scoreboard bench for video_shift_tap_ctrl with a behavioural line RAM.
module tb_video_shift_tap_ctrl;
    localparam int DW   = 24;
    localparam int AW   = 4;
    localparam int MAXL = 16;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          in_vs;
    logic          in_de;
    logic [DW-1:0] in_data;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          out_de;
    logic [DW-1:0] out_cur;
    logic [DW-1:0] out_prev;
    logic          out_prev_vld;
    logic [AW:0]   line_len;
`ifdef SHIFT_TAP_LINE_CNT_EN
    logic [11:0]   line_cnt;
`endif
    logic          overflow;

    always #5 clock = ~clock;

    video_shift_tap_ctrl #(.DSIZE(DW), .ASIZE(AW)) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .in_vs        (in_vs),
        .in_de        (in_de),
        .in_data      (in_data),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .out_de       (out_de),
        .out_cur      (out_cur),
        .out_prev     (out_prev),
        .out_prev_vld (out_prev_vld),
        .line_len     (line_len),
`ifdef SHIFT_TAP_LINE_CNT_EN
        .line_cnt     (line_cnt),
`endif
        .overflow     (overflow)
    );

    logic [DW-1:0] mem [MAXL];
    always_ff @(posedge clock) begin
        if (ram_wr_en)
            mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en)
            ram_rd_data <= mem[ram_rd_addr];
    end

    typedef struct {
        logic          de;
        logic [DW-1:0] cur;
        logic          vld;
        logic [DW-1:0] prev;
        logic          wr;
        logic [AW-1:0] waddr;
        logic          ovf;
    } exp_t;

    exp_t          sb[$];
    int            passed = 0;
    int            total  = 0;
    bit            have_prev;
    bit            ovf_m;
    int            prev_len;
    logic [DW-1:0] prev_line [MAXL];
    logic [DW-1:0] cur_line  [MAXL];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input bit vs, input bit de, input logic [DW-1:0] d,
                       input int c, input bit vld, input logic [DW-1:0] prev);
        exp_t e;
        int   ce;
        bit   acc;
        ce  = vs ? 0 : ((c > MAXL) ? MAXL : c);
        acc = de && (ce < MAXL);
        in_vs   = vs;
        in_de   = de;
        in_data = d;
        #1;
        chk("rd_en", 32'(ram_rd_en), 32'(acc));
        if (acc)
            chk("rd_addr", 32'(ram_rd_addr), 32'(ce % MAXL));
        if (vs)
            ovf_m = 1'b0;
        else if (de && ce >= MAXL)
            ovf_m = 1'b1;
        e.de    = de;
        e.cur   = d;
        e.vld   = vld;
        e.prev  = prev;
        e.wr    = acc;
        e.waddr = AW'(ce % MAXL);
        e.ovf   = ovf_m;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("out_de", 32'(out_de), 32'(e.de));
        if (e.de)
            chk("out_cur", 32'(out_cur), 32'(e.cur));
        chk("prev_vld", 32'(out_prev_vld), 32'(e.vld));
        if (e.vld)
            chk("out_prev", 32'(out_prev), 32'(e.prev));
        chk("wr_en", 32'(ram_wr_en), 32'(e.wr));
        if (e.wr) begin
            chk("wr_addr", 32'(ram_wr_addr), 32'(e.waddr));
            chk("wr_data", 32'(ram_wr_data), 32'(e.cur));
        end
        chk("overflow", 32'(overflow), 32'(e.ovf));
    endtask

    task automatic send_line(input int n, input logic [DW-1:0] base,
                             input bit vs_first);
        bit            v;
        logic [DW-1:0] p;
        logic [DW-1:0] d;
        if (vs_first)
            have_prev = 1'b0;
        for (int c = 0; c < n; c++) begin
            v = have_prev && (c < prev_len) && (c < MAXL);
            p = (c < MAXL) ? prev_line[c] : '0;
            d = DW'(32'(base) + c);
            cyc(vs_first && c == 0, 1'b1, d, c, v, p);
            if (c < MAXL)
                cur_line[c] = d;
        end
        cyc(1'b0, 1'b0, '0, 0, 1'b0, '0);
        prev_len = (n < MAXL) ? n : MAXL;
        chk("line_len", 32'(line_len), 32'(prev_len));
        for (int c = 0; c < prev_len; c++)
            prev_line[c] = cur_line[c];
        have_prev = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_vs     = 1'b0;
        in_de     = 1'b0;
        in_data   = '0;
        have_prev = 1'b0;
        ovf_m     = 1'b0;
        prev_len  = 0;
        #12;
        chk("rst_out_de", 32'(out_de), 32'd0);
        chk("rst_vld", 32'(out_prev_vld), 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_line_len", 32'(line_len), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        cyc(1'b1, 1'b0, '0, 0, 1'b0, '0);
        have_prev = 1'b0;
        send_line(8, 24'h000, 1'b0);
        send_line(8, 24'h010, 1'b0);
        send_line(12, 24'h020, 1'b0);
        send_line(18, 24'h040, 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        send_line(8, 24'h060, 1'b0);
        chk("ovf_held", 32'(overflow), 32'd1);
        cyc(1'b1, 1'b0, '0, 0, 1'b0, '0);
        have_prev = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        send_line(8, 24'h070, 1'b0);
        send_line(8, 24'h080, 1'b1);
        send_line(8, 24'h090, 1'b0);

        for (int c = 0; c < 3; c++)
            cyc(1'b0, 1'b1, DW'(32'h0a0 + c), c, 1'b1, prev_line[c]);
        rst_n = 1'b0;
        #1;
        chk("mid_out_de", 32'(out_de), 32'd0);
        chk("mid_vld", 32'(out_prev_vld), 32'd0);
        chk("mid_wr_en", 32'(ram_wr_en), 32'd0);
        chk("mid_rd_en", 32'(ram_rd_en), 32'd0);
        chk("mid_line_len", 32'(line_len), 32'd0);
        chk("mid_overflow", 32'(overflow), 32'd0);
        in_de = 1'b0;
        @(posedge clock);
        #1;
        rst_n     = 1'b1;
        have_prev = 1'b0;
        prev_len  = 0;
        ovf_m     = 1'b0;
        send_line(8, 24'h0b0, 1'b0);
        send_line(8, 24'h0c0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
